// File: rtl/interrupt_scheduler.sv
// Interrupt scheduler: latches peripheral interrupt factors, applies the mask,
// and runs the request/ack/service handshake toward the microcode sequencer.
module interrupt_scheduler #(
    parameter int NUM_SOURCES = 6,
    parameter int VECTOR_BASE = 2,
    parameter int VECTOR_STEP = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_SOURCES-1:0]         source_event,
    input  logic                           mask_wr,
    input  logic [NUM_SOURCES-1:0]         mask_wr_data,
    input  logic                           factor_rd,
    input  logic [$clog2(NUM_SOURCES)-1:0] factor_rd_index,
    input  logic                           interrupt_flag,
    input  logic                           instr_boundary,
    input  logic                           cpu_halted,
    input  logic                           irq_ack,
    input  logic                           service_done,
    output logic [NUM_SOURCES-1:0]         factor_flags,
    output logic [NUM_SOURCES-1:0]         mask,
    output logic                           irq_req,
    output logic [3:0]                     irq_vector,
    output logic                           in_service,
    output logic                           wake
);

    localparam int IDX_W = $clog2(NUM_SOURCES);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERVICE
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic                   req_next;
    logic                   service_next;
    logic [3:0]             vector_next;
    logic [3:0]             top_vector;
    logic [NUM_SOURCES-1:0] pending;
    logic                   any_pending;
    logic                   iflag_q;
    logic                   ei_rise;
    logic                   inhibit;
    logic                   boundary_seen;
    logic                   halt_cond;
    logic                   halt_cond_q;

    assign pending     = factor_flags & mask;
    assign any_pending = |pending;
    assign ei_rise     = interrupt_flag && !iflag_q;
    assign halt_cond   = cpu_halted && any_pending;

    // A new event outranks a software read of the same flag in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            factor_flags <= '0;
        end else begin
            for (int i = 0; i < NUM_SOURCES; i++) begin
                if (source_event[i]) begin
                    factor_flags[i] <= 1'b1;
                end else if (factor_rd && factor_rd_index == IDX_W'(i)) begin
                    factor_flags[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mask <= '0;
        end else if (mask_wr) begin
            mask <= mask_wr_data;
        end
    end

    // Ascending scan so the highest pending index wins.
    always_comb begin
        top_vector = 4'(VECTOR_BASE);
        for (int i = 0; i < NUM_SOURCES; i++) begin
            if (pending[i]) begin
                top_vector = 4'(VECTOR_BASE + VECTOR_STEP * i);
            end
        end
    end

    // EI inhibit lasts until the second instruction boundary after it is armed.
    always_ff @(posedge clk) begin
        if (reset) begin
            iflag_q       <= 1'b0;
            inhibit       <= 1'b0;
            boundary_seen <= 1'b0;
        end else begin
            iflag_q <= interrupt_flag;
            if (ei_rise) begin
                inhibit       <= 1'b1;
                boundary_seen <= 1'b0;
            end else if (inhibit && instr_boundary) begin
                if (boundary_seen) begin
                    inhibit       <= 1'b0;
                    boundary_seen <= 1'b0;
                end else begin
                    boundary_seen <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            irq_req    <= 1'b0;
            irq_vector <= 4'd0;
            in_service <= 1'b0;
        end else begin
            state      <= state_next;
            irq_req    <= req_next;
            irq_vector <= vector_next;
            in_service <= service_next;
        end
    end

    // The EI edge itself also blocks a request; the inhibit register only
    // becomes visible one cycle later.
    always_comb begin
        state_next   = state;
        req_next     = irq_req;
        vector_next  = irq_vector;
        service_next = in_service;
        case (state)
            IDLE: begin
                if (interrupt_flag && any_pending && !inhibit && !ei_rise) begin
                    state_next  = REQ;
                    req_next    = 1'b1;
                    vector_next = top_vector;
                end
            end
            REQ: begin
                if (irq_ack) begin
                    state_next   = SERVICE;
                    req_next     = 1'b0;
                    service_next = 1'b1;
                end else if (!interrupt_flag || !any_pending) begin
                    state_next = IDLE;
                    req_next   = 1'b0;
                end else begin
                    vector_next = top_vector;
                end
            end
            SERVICE: begin
                if (service_done) begin
                    state_next   = IDLE;
                    service_next = 1'b0;
                end
            end
            default: begin
                state_next   = IDLE;
                req_next     = 1'b0;
                service_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            halt_cond_q <= 1'b0;
            wake        <= 1'b0;
        end else begin
            halt_cond_q <= halt_cond;
            wake        <= halt_cond && !halt_cond_q;
        end
    end

endmodule

// File: tb/tb_interrupt_scheduler.sv
// Scoreboard bench for interrupt_scheduler: a cycle model pushes expected
// outputs as each stimulus is driven; they are popped and compared after the edge.
module tb_interrupt_scheduler;

    localparam int NUM_SOURCES = 6;
    localparam int VECTOR_BASE = 2;
    localparam int VECTOR_STEP = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] source_event;
    logic       mask_wr;
    logic [5:0] mask_wr_data;
    logic       factor_rd;
    logic [2:0] factor_rd_index;
    logic       interrupt_flag;
    logic       instr_boundary;
    logic       cpu_halted;
    logic       irq_ack;
    logic       service_done;
    logic [5:0] factor_flags;
    logic [5:0] mask;
    logic       irq_req;
    logic [3:0] irq_vector;
    logic       in_service;
    logic       wake;

    always #5 clk = ~clk;

    interrupt_scheduler #(
        .NUM_SOURCES(NUM_SOURCES),
        .VECTOR_BASE(VECTOR_BASE),
        .VECTOR_STEP(VECTOR_STEP)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .source_event   (source_event),
        .mask_wr        (mask_wr),
        .mask_wr_data   (mask_wr_data),
        .factor_rd      (factor_rd),
        .factor_rd_index(factor_rd_index),
        .interrupt_flag (interrupt_flag),
        .instr_boundary (instr_boundary),
        .cpu_halted     (cpu_halted),
        .irq_ack        (irq_ack),
        .service_done   (service_done),
        .factor_flags   (factor_flags),
        .mask           (mask),
        .irq_req        (irq_req),
        .irq_vector     (irq_vector),
        .in_service     (in_service),
        .wake           (wake)
    );

    typedef struct packed {
        logic       rst;
        logic [5:0] ev;
        logic       mwr;
        logic [5:0] mdata;
        logic       rd;
        logic [2:0] ridx;
        logic       iflag;
        logic       bnd;
        logic       halted;
        logic       ack;
        logic       done;
    } stim_t;

    typedef struct packed {
        logic [5:0] flags;
        logic [5:0] mask;
        logic       req;
        logic [3:0] vec;
        logic       insvc;
        logic       wake;
    } exp_t;

    exp_t  sb[$];
    stim_t s;
    int    vectors = 0;
    int    miscompares = 0;
    int    cycle = 0;

    // Reference model state (0 idle, 1 requesting, 2 servicing)
    logic [5:0] m_flags, m_mask;
    int         m_state;
    logic       m_req, m_insvc, m_wake, m_iprev, m_inh, m_cnt, m_wcond;
    logic [3:0] m_vec;

    function automatic logic [3:0] vectorOf(input logic [5:0] pend);
        for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
            if (pend[i]) return 4'((VECTOR_BASE + VECTOR_STEP * i) % 16);
        end
        return 4'(VECTOR_BASE);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
        vectors++;
        if (got !== expv) begin
            miscompares++;
            $display("[TB] FAIL %s (cycle %0d): got %0h, expected %0h", tag, cycle, got, expv);
        end
    endtask

    task automatic modelStep(input stim_t st);
        logic [5:0] pend;
        logic       rise;
        logic       cond;
        if (st.rst) begin
            m_flags = '0; m_mask = '0; m_state = 0; m_req = 0; m_vec = '0;
            m_insvc = 0; m_wake = 0; m_iprev = 0; m_inh = 0; m_cnt = 0; m_wcond = 0;
            return;
        end
        pend = m_flags & m_mask;
        rise = st.iflag && !m_iprev;
        if (m_state == 0) begin
            if (st.iflag && pend != 0 && !m_inh && !rise) begin
                m_state = 1; m_req = 1; m_vec = vectorOf(pend);
            end
        end else if (m_state == 1) begin
            if (st.ack) begin
                m_state = 2; m_req = 0; m_insvc = 1;
            end else if (!st.iflag || pend == 0) begin
                m_state = 0; m_req = 0;
            end else begin
                m_vec = vectorOf(pend);
            end
        end else if (st.done) begin
            m_state = 0; m_insvc = 0;
        end
        cond    = st.halted && (pend != 0);
        m_wake  = cond && !m_wcond;
        m_wcond = cond;
        if (rise) begin
            m_inh = 1; m_cnt = 0;
        end else if (m_inh && st.bnd) begin
            if (m_cnt) begin m_inh = 0; m_cnt = 0; end
            else m_cnt = 1;
        end
        m_flags = (m_flags | st.ev);
        if (st.rd && st.ridx < 3'(NUM_SOURCES) && !st.ev[st.ridx]) m_flags[st.ridx] = 1'b0;
        if (st.mwr) m_mask = st.mdata;
        m_iprev = st.iflag;
    endtask

    task automatic applyStimulus(input stim_t st);
        exp_t e;
        reset           = st.rst;
        source_event    = st.ev;
        mask_wr         = st.mwr;
        mask_wr_data    = st.mdata;
        factor_rd       = st.rd;
        factor_rd_index = st.ridx;
        interrupt_flag  = st.iflag;
        instr_boundary  = st.bnd;
        cpu_halted      = st.halted;
        irq_ack         = st.ack;
        service_done    = st.done;
        modelStep(st);
        sb.push_back('{m_flags, m_mask, m_req, m_vec, m_insvc, m_wake});
        @(posedge clk);
        #1;
        cycle++;
        e = sb.pop_front();
        checkOutput("factor_flags", 32'(factor_flags), 32'(e.flags));
        checkOutput("mask",         32'(mask),         32'(e.mask));
        checkOutput("irq_req",      32'(irq_req),      32'(e.req));
        checkOutput("irq_vector",   32'(irq_vector),   32'(e.vec));
        checkOutput("in_service",   32'(in_service),   32'(e.insvc));
        checkOutput("wake",         32'(wake),         32'(e.wake));
    endtask

    task automatic tick();
        applyStimulus(s);
        s.rst = 0; s.ev = '0; s.mwr = 0; s.rd = 0; s.bnd = 0; s.ack = 0; s.done = 0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Raise I and let two instruction boundaries pass so requests are allowed.
    task automatic enableInterrupts();
        s.iflag = 1; tick();
        s.bnd = 1; tick();
        s.bnd = 1; tick();
    endtask

    initial begin
        s = '0;
        s.rst = 1; tick();
        s.rst = 1; tick();
        checkOutput("rst_req",   32'(irq_req),      32'(0));
        checkOutput("rst_flags", 32'(factor_flags), 32'(0));

        // Single source
        s.mwr = 1; s.mdata = 6'b000001; tick();
        enableInterrupts();
        idle(1);
        s.ev = 6'b000001; tick();
        checkOutput("single_req_early", 32'(irq_req), 32'(0));
        tick();
        checkOutput("single_req", 32'(irq_req), 32'(1));
        checkOutput("single_vec", 32'(irq_vector), 32'(2));
        s.ack = 1; s.bnd = 1; s.iflag = 0; tick();
        checkOutput("ack_req_low", 32'(irq_req), 32'(0));
        checkOutput("ack_in_service", 32'(in_service), 32'(1));
        idle(3);
        s.done = 1; tick();
        checkOutput("done_in_service", 32'(in_service), 32'(0));
        checkOutput("flag0_sticky", 32'(factor_flags[0]), 32'(1));
        s.rd = 1; s.ridx = 3'd0; tick();
        checkOutput("flag0_read_clear", 32'(factor_flags[0]), 32'(0));

        // Priority and preemption before ack
        s.mwr = 1; s.mdata = 6'h3F; tick();
        enableInterrupts();
        s.ev = 6'b000101; tick(); tick();
        checkOutput("prio_vec", 32'(irq_vector), 32'(6));
        s.ev = 6'b100000; tick(); tick();
        checkOutput("preempt_vec", 32'(irq_vector), 32'(12));
        s.ack = 1; s.bnd = 1; s.iflag = 0; tick();
        idle(3);
        checkOutput("frozen_vec", 32'(irq_vector), 32'(12));
        s.done = 1; tick();
        foreach (s.ev[i]) begin
            s.rd = 1; s.ridx = 3'(i); tick();
        end

        // Masking and withdraw
        s.mwr = 1; s.mdata = '0; tick();
        enableInterrupts();
        s.ev = 6'b001000; tick();
        idle(2);
        checkOutput("masked_no_req", 32'(irq_req), 32'(0));
        s.mwr = 1; s.mdata = 6'b001000; tick(); tick();
        checkOutput("unmask_req", 32'(irq_req), 32'(1));
        checkOutput("unmask_vec", 32'(irq_vector), 32'(8));
        s.iflag = 0; tick();
        checkOutput("withdraw_req", 32'(irq_req), 32'(0));
        idle(1);

        // EI inhibit with flag 3 already pending
        s.iflag = 1; tick(); idle(2);
        checkOutput("ei_inhibit_0", 32'(irq_req), 32'(0));
        s.bnd = 1; tick(); idle(2);
        checkOutput("ei_inhibit_1", 32'(irq_req), 32'(0));
        s.bnd = 1; tick(); tick();
        checkOutput("ei_release", 32'(irq_req), 32'(1));
        s.iflag = 0; tick();
        s.rd = 1; s.ridx = 3'd3; tick();

        // Read/clear race and out-of-range read index
        s.ev = 6'b010000; s.rd = 1; s.ridx = 3'd4; tick();
        checkOutput("race_set_wins", 32'(factor_flags[4]), 32'(1));
        s.rd = 1; s.ridx = 3'd4; tick();
        checkOutput("race_clear", 32'(factor_flags[4]), 32'(0));
        s.ev = 6'b000001; tick();
        s.rd = 1; s.ridx = 3'd6; tick();
        s.rd = 1; s.ridx = 3'd7; tick();
        checkOutput("oob_read_ignored", 32'(factor_flags), 32'(1));
        s.rd = 1; s.ridx = 3'd0; tick();

        // HALT wake with I clear
        s.mwr = 1; s.mdata = 6'b000010; tick();
        s.halted = 1; tick();
        s.ev = 6'b000010; tick(); tick();
        checkOutput("wake_pulse", 32'(wake), 32'(1));
        checkOutput("wake_no_req", 32'(irq_req), 32'(0));
        tick();
        checkOutput("wake_single", 32'(wake), 32'(0));
        idle(2);
        s.halted = 0; s.rd = 1; s.ridx = 3'd1; tick();

        // Reset during SERVICE
        s.mwr = 1; s.mdata = 6'h3F; tick();
        enableInterrupts();
        s.ev = 6'b010000; tick(); tick();
        s.ack = 1; s.bnd = 1; s.iflag = 0; tick();
        checkOutput("svc_before_reset", 32'(in_service), 32'(1));
        s.rst = 1; tick();
        checkOutput("reset_in_service", 32'(in_service), 32'(0));
        checkOutput("reset_flags", 32'(factor_flags), 32'(0));
        checkOutput("reset_mask", 32'(mask), 32'(0));

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            s.ev    = ($urandom_range(0, 5) == 0) ? 6'($urandom) : 6'd0;
            s.mwr   = ($urandom_range(0, 15) == 0);
            s.mdata = 6'($urandom);
            s.rd    = ($urandom_range(0, 3) == 0);
            s.ridx  = 3'($urandom);
            if ($urandom_range(0, 9) == 0) s.iflag = ~s.iflag;
            if ($urandom_range(0, 19) == 0) s.halted = ~s.halted;
            s.bnd   = ($urandom_range(0, 2) == 0);
            s.ack   = s.bnd && ($urandom_range(0, 1) == 0);
            s.done  = ($urandom_range(0, 5) == 0);
            s.rst   = ($urandom_range(0, 99) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/interrupt_scheduler.md
Name: interrupt_scheduler

Overview:
Arbitrates the CPU's six interrupt factor groups into a single interrupt request for the microcode sequencer. Latches source events into factor flags and applies the mask register. Sequences the request/acknowledge/service handshake at instruction boundaries, enforces the one-instruction inhibit after EI, and generates the HALT wake pulse. It sits between the peripherals (timers, serial, K ports) and the CPU core.

Parameters:
NUM_SOURCES, 6, number of interrupt factor groups; index 0 is the lowest priority, index NUM_SOURCES-1 is the highest.
VECTOR_BASE, 2, vector for index 0.
VECTOR_STEP, 2, vector increment per index: vector = VECTOR_BASE + VECTOR_STEP*index, truncated to 4 bits.

Ports:
clk  in  1  system clock; the only clock.
reset  in  1  synchronous, active-high reset.
source_event  in  NUM_SOURCES  one-cycle event pulse per factor group (0 clock timer, 1 stopwatch, 2 K00-03, 3 K10-13, 4 serial, 5 prog timer).
mask_wr  in  1  write strobe for the mask register.
mask_wr_data  in  NUM_SOURCES  new mask value; 1 = enabled.
factor_rd  in  1  CPU read of one factor flag; the read clears that flag.
factor_rd_index  in  $clog2(NUM_SOURCES)  flag index being read.
interrupt_flag  in  1  CPU I flag.
instr_boundary  in  1  one-cycle pulse when the CPU enters DECODE.
cpu_halted  in  1  CPU is in HALT.
irq_ack  in  1  CPU accepted the request; one-cycle pulse, only on an instr_boundary cycle.
service_done  in  1  interrupt entry microcode finished (PC pushed, vector loaded).
factor_flags  out  NUM_SOURCES  latched factor flags.
mask  out  NUM_SOURCES  mask register.
irq_req  out  1  interrupt request to the sequencer.
irq_vector  out  4  vector of the highest-priority pending source.
in_service  out  1  interrupt entry sequence is in progress.
wake  out  1  one-cycle HALT release pulse.

Behaviour:
- Reset values: factor_flags=0, mask=0, irq_req=0, irq_vector=0, in_service=0, wake=0, state=IDLE, inhibit=0.
- Factor flag[i]:
  - Set on source_event[i].
  - Cleared on factor_rd with factor_rd_index==i.
  - Set and clear in the same cycle: set wins.
  - factor_rd_index >= NUM_SOURCES is ignored.
  - Flags are never cleared by ack or by service; software clears them.
- mask: updated on mask_wr. The new value affects pending one cycle later.
- pending = factor_flags & mask, evaluated on registered values.
- inhibit:
  - Set on the cycle after a rising edge of interrupt_flag (EI).
  - Cleared on the second instr_boundary after it is set, so one full instruction executes first.
- States:
  - IDLE -> REQ when interrupt_flag && |pending && !inhibit. Entering REQ registers irq_req=1.
  - REQ: irq_vector is recomputed every cycle from the highest set bit of pending, so a later higher-priority event preempts before ack.
  - REQ -> IDLE with irq_req=0 next cycle if interrupt_flag drops or pending becomes 0 before ack.
  - REQ -> SERVICE on irq_ack. At that point irq_req=0, in_service=1, and irq_vector is frozen.
  - SERVICE -> IDLE on service_done; in_service=0. No new request is raised while in SERVICE.
  - irq_ack outside REQ is ignored. service_done outside SERVICE is ignored.
- Latency:
  - Event to irq_req = 2 cycles: flag set, then request registered.
  - irq_ack to irq_req deassert = 1 cycle.
- Re-request: after SERVICE, a still-set flag re-requests once I is set again and the inhibit rules are satisfied. The CPU clears I on entry, so this does not happen immediately.
- wake: one-cycle pulse on the rising edge of (cpu_halted && |pending), independent of interrupt_flag. It is not re-pulsed while the condition stays high.
- Reset mid-REQ or mid-SERVICE returns all state to reset values on the next clk.

Test Plan:
- Single source: mask=6'b000001, I=1, source_event[0] pulse -> irq_req high 2 cycles later, irq_vector=2; irq_ack -> irq_req low, in_service=1; service_done -> IDLE; factor_flags[0] still 1 until factor_rd index 0.
- Priority/preempt: events 0 and 2 together, mask=3F -> vector=6; event 5 before ack -> vector=12 (0xC); ack -> vector held at 0xC through SERVICE.
- Masking and withdraw: event 3 with mask=0 -> no irq_req; mask_wr 6'b001000 -> irq_req 2 cycles later, vector=8; drop I in REQ -> irq_req low next cycle, state IDLE.
- EI inhibit: flag pending, I rises -> irq_req stays low through the first instr_boundary and asserts only after the second.
- Read-clear race: source_event[4] and factor_rd index 4 in the same cycle -> flag[4]=1; factor_rd alone next cycle -> 0.
- HALT wake and reset: cpu_halted=1, I=0, masked event 1 -> single wake pulse, no irq_req; reset asserted during SERVICE -> in_service=0, flags=0, mask=0.
